// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave in the clk domain: SCLK/CS_N/MOSI are oversampled, never used as clocks.
// Receives MSB-first words onto rx_data and shifts a held response word out on MISO.
module spi_slave_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);
    localparam int            CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic [SYNC_STAGES:0]   arm_pipe;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, mosi_s, cs_s, armed;
    logic                   rise, fall, cs_fall, cs_rise;
    logic                   load_word, word_done;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_WIDTH-1:0]  tx_shift, rx_shift, hold;
    logic                   hold_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            arm_pipe  <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            arm_pipe  <= {arm_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    // The cs synchroniser resets high; hold off cs_fall until the real pin level has
    // flushed through, so a cs_n held low across reset does not open a frame.
    assign armed   = arm_pipe[SYNC_STAGES];
    assign rise    = sclk_s & ~sclk_d;
    assign fall    = ~sclk_s & sclk_d;
    assign cs_fall = armed & ~cs_s & cs_d;
    assign cs_rise = cs_s & ~cs_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cs_fall) state_d = LOAD;
                LOAD:    state_d = SHIFT;
                SHIFT:   state_d = SHIFT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        miso = 1'b0;
        if (state_q == SHIFT) miso = tx_shift[DATA_WIDTH-1];
    end

    assign busy     = ~cs_s;
    assign tx_ready = ~hold_full;
    // A new tx word is needed at frame start and on the first fall after each completed word.
    assign load_word = ~cs_rise &
                       ((state_q == LOAD) || ((state_q == SHIFT) && fall && word_done));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            bit_cnt     <= '0;
            word_done   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            if (cs_rise) begin
                tx_shift  <= '0;
                rx_shift  <= '0;
                bit_cnt   <= '0;
                word_done <= 1'b0;
            end else begin
                if (load_word) begin
                    tx_shift    <= hold_full ? hold : '0;
                    tx_underrun <= ~hold_full;
                    word_done   <= 1'b0;
                end else if ((state_q == SHIFT) && fall) begin
                    tx_shift <= tx_shift << 1;
                end
                if ((state_q == SHIFT) && rise) begin
                    rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt == LAST_BIT) begin
                        rx_data   <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                        rx_valid  <= 1'b1;
                        bit_cnt   <= '0;
                        word_done <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Transfer only happens when full, so it can never coincide with an accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (load_word && hold_full) begin
            hold_full <= 1'b0;
        end else if (tx_valid && !hold_full) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench for spi_slave_responder: bit-banged SPI master at clk/8 plus a
// word-level model (queue of accepted tx words, expected underruns, received words).
module tb_spi_slave_responder;
    localparam int W    = 8;
    localparam int HALF = 4;

    logic         clk = 1'b0, reset = 1'b0;
    logic         sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic         miso, tx_ready, rx_valid, tx_underrun, busy;
    logic         tx_valid = 1'b0;
    logic [W-1:0] tx_data = '0, rx_data;

    int           passed = 0, total = 0;
    int           under_cnt = 0, exp_under = 0;
    logic [W-1:0] offer_q[$], acc_q[$], rx_q[$];
    logic [W-1:0] mosi_buf[0:15], miso_buf[0:15];
    logic [W-1:0] last_rx = '0;
    logic         prev_acc = 1'b0;
    logic [W-1:0] prev_data = '0;

    always #5 clk = ~clk;

    spi_slave_responder #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
    );

    // Offers queued words with continuous tx_valid; records accepts, rx words, underrun pulses.
    initial begin : feeder
        forever begin
            @(negedge clk);
            if (prev_acc) begin
                acc_q.push_back(prev_data);
                offer_q.delete(0);
            end
            if (offer_q.size() > 0) begin
                tx_valid = 1'b1;
                tx_data  = offer_q[0];
            end else begin
                tx_valid = 1'b0;
            end
            prev_acc  = tx_valid && tx_ready && !reset;
            prev_data = tx_data;
            if (rx_valid) rx_q.push_back(rx_data);
            if (tx_underrun) under_cnt++;
        end
    end

    // Each started tx word slot takes the oldest accepted word, or 0 with an underrun.
    function automatic logic [W-1:0] take_word();
        logic [W-1:0] w;
        if (acc_q.size() > 0) begin
            w = acc_q.pop_front();
        end else begin
            w = '0;
            exp_under++;
        end
        return w;
    endfunction

    task automatic spi_frame(input int nbits, input bit raise_cs);
        cs_n = 1'b0;
        mosi = mosi_buf[0][W-1];
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            repeat (HALF) @(negedge clk);
            miso_buf[i / W][W-1-(i % W)] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            if (i == nbits - 1) begin
                if (raise_cs) cs_n = 1'b1;
            end else begin
                mosi = mosi_buf[(i+1) / W][W-1-((i+1) % W)];
            end
        end
        if (nbits == 0 && raise_cs) cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_offer_drain(input string name);
        int n = 0;
        while (offer_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        total++;
        if (offer_q.size() != 0) $display("FAIL %s_accept: %0d words pending, want 0", name, offer_q.size());
        else passed++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({miso, tx_ready, rx_data, rx_valid, tx_underrun, busy} !== {1'b0, 1'b1, 8'h00, 3'b000})
            $display("FAIL reset_outputs: got miso=%b rdy=%b rx=%h rv=%b ur=%b busy=%b, want 0 1 00 0 0 0",
                     miso, tx_ready, rx_data, rx_valid, tx_underrun, busy);
        else passed++;
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_single();
        logic [W-1:0] e;
        rx_q.delete();
        offer_q.push_back(8'hA5);
        wait_offer_drain("single");
        mosi_buf[0] = 8'h3C;
        spi_frame(8, 1);
        e = take_word();
        total++;
        if (miso_buf[0] !== e) $display("FAIL single_miso: got %h want %h", miso_buf[0], e);
        else passed++;
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h3C)
            $display("FAIL single_rx: got %0d words first %h, want 1 word 3c", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        else passed++;
        total++;
        if (under_cnt != exp_under) $display("FAIL single_underrun: got %0d want %0d", under_cnt, exp_under);
        else passed++;
        last_rx = 8'h3C;
    endtask

    task automatic test_two_words();
        logic [W-1:0] e;
        rx_q.delete();
        offer_q.push_back(8'h11);
        offer_q.push_back(8'h22);
        repeat (4) @(negedge clk);
        mosi_buf[0] = 8'hDE;
        mosi_buf[1] = 8'hAD;
        spi_frame(16, 1);
        for (int k = 0; k < 2; k++) begin
            e = take_word();
            total++;
            if (miso_buf[k] !== e) $display("FAIL two_miso%0d: got %h want %h", k, miso_buf[k], e);
            else passed++;
        end
        total++;
        if (rx_q.size() != 2) $display("FAIL two_rx_count: got %0d want 2", rx_q.size());
        else passed++;
        for (int k = 0; k < 2 && k < rx_q.size(); k++) begin
            total++;
            if (rx_q[k] !== mosi_buf[k]) $display("FAIL two_rx%0d: got %h want %h", k, rx_q[k], mosi_buf[k]);
            else passed++;
        end
        total++;
        if (under_cnt != exp_under) $display("FAIL two_underrun: got %0d want %0d", under_cnt, exp_under);
        else passed++;
        last_rx = 8'hAD;
    endtask

    task automatic test_underrun();
        logic [W-1:0] e;
        rx_q.delete();
        mosi_buf[0] = 8'hFF;
        spi_frame(8, 1);
        e = take_word();
        total++;
        if (miso_buf[0] !== e) $display("FAIL underrun_miso: got %h want %h", miso_buf[0], e);
        else passed++;
        total++;
        if (under_cnt != exp_under) $display("FAIL underrun_count: got %0d want %0d", under_cnt, exp_under);
        else passed++;
        total++;
        if (rx_q.size() != 1 || rx_data !== 8'hFF) $display("FAIL underrun_rx: got %0d words rx_data %h, want 1 word ff", rx_q.size(), rx_data);
        else passed++;
        last_rx = 8'hFF;
    endtask

    task automatic test_abort();
        logic [W-1:0] e;
        rx_q.delete();
        offer_q.push_back(8'h5A);
        wait_offer_drain("abort");
        mosi_buf[0] = 8'hF0;
        spi_frame(4, 1);
        void'(take_word());
        total++;
        if (rx_q.size() != 0 || rx_data !== last_rx)
            $display("FAIL abort_rx: got %0d words rx_data %h, want 0 words %h", rx_q.size(), rx_data, last_rx);
        else passed++;
        total++;
        if (busy !== 1'b0 || tx_ready !== 1'b1) $display("FAIL abort_status: got busy=%b rdy=%b want 0 1", busy, tx_ready);
        else passed++;
        offer_q.push_back(8'h96);
        wait_offer_drain("abort_next");
        total++;
        if (tx_ready !== 1'b0) $display("FAIL abort_hold_full: got rdy=%b want 0", tx_ready);
        else passed++;
        mosi_buf[0] = 8'hC3;
        spi_frame(8, 1);
        e = take_word();
        total++;
        if (miso_buf[0] !== e || rx_q.size() != 1 || rx_data !== 8'hC3)
            $display("FAIL abort_next_frame: got miso %h rx %h (%0d words), want %h c3 (1)", miso_buf[0], rx_data, rx_q.size(), e);
        else passed++;
        total++;
        if (tx_ready !== 1'b1 || under_cnt != exp_under)
            $display("FAIL abort_after: got rdy=%b underruns=%0d want 1 %0d", tx_ready, under_cnt, exp_under);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] e;
        int ub;
        rx_q.delete();
        mosi_buf[0] = W'($urandom);
        spi_frame(5, 0);
        void'(take_word());
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({miso, tx_ready, rx_data, rx_valid, tx_underrun, busy} !== {1'b0, 1'b1, 8'h00, 3'b000})
                $display("FAIL midreset_outputs%0d: got miso=%b rdy=%b rx=%h rv=%b ur=%b busy=%b, want 0 1 00 0 0 0",
                         c, miso, tx_ready, rx_data, rx_valid, tx_underrun, busy);
            else passed++;
        end
        reset = 1'b0;
        acc_q.delete();
        ub = under_cnt;
        exp_under = under_cnt;
        repeat (10) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            mosi = 1'($urandom);
            repeat (HALF) @(negedge clk);
            total++;
            if (miso !== 1'b0) $display("FAIL midreset_miso%0d: got %b want 0", b, miso);
            else passed++;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        total++;
        if (rx_q.size() != 0 || under_cnt != ub) $display("FAIL midreset_quiet: got %0d words %0d underruns, want 0 %0d", rx_q.size(), under_cnt, ub);
        else passed++;
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        mosi_buf[0] = 8'h81;
        spi_frame(8, 1);
        e = take_word();
        total++;
        if (miso_buf[0] !== e || rx_q.size() != 1 || rx_data !== 8'h81)
            $display("FAIL midreset_frame: got miso %h rx %h (%0d words), want %h 81 (1)", miso_buf[0], rx_data, rx_q.size(), e);
        else passed++;
        total++;
        if (under_cnt != exp_under) $display("FAIL midreset_underrun: got %0d want %0d", under_cnt, exp_under);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_rx[$];
        logic [W-1:0] e;
        int bad = 0;
        rx_q.delete();
        for (int k = 0; k < 16; k++) offer_q.push_back(W'($urandom));
        repeat (4) @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 4; k++) begin
                mosi_buf[k] = W'($urandom);
                exp_rx.push_back(mosi_buf[k]);
            end
            spi_frame(32, 1);
            for (int k = 0; k < 4; k++) begin
                e = take_word();
                total++;
                if (miso_buf[k] !== e) begin
                    $display("FAIL b2b_miso f%0d w%0d: got %h want %h", f, k, miso_buf[k], e);
                    bad++;
                end else passed++;
            end
        end
        wait_offer_drain("b2b");
        total++;
        if (rx_q.size() != exp_rx.size()) $display("FAIL b2b_rx_count: got %0d want %0d", rx_q.size(), exp_rx.size());
        else passed++;
        for (int k = 0; k < exp_rx.size() && k < rx_q.size(); k++) begin
            total++;
            if (rx_q[k] !== exp_rx[k]) $display("FAIL b2b_rx%0d: got %h want %h", k, rx_q[k], exp_rx[k]);
            else passed++;
        end
        total++;
        if (under_cnt != exp_under) $display("FAIL b2b_underrun: got %0d want %0d", under_cnt, exp_under);
        else passed++;
    endtask

    initial begin
        #1 reset = 1'b1;
        test_reset();
        test_single();
        test_two_words();
        test_underrun();
        test_abort();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
